// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : calc_pkg                                                  |
// | Purpose  : Shared constants and types for the calc arbiter slice     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package calc_pkg;

  // Default calc datapath width
  localparam int CALC_W = 4;

  // Operation select encoding
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/calc_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : calc_arbiter_if                                           |
// | Purpose  : Request/response bundle between clients and calc_arbiter  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface calc_arbiter_if #(
  parameter int W     = calc_pkg::CALC_W,
  parameter int CNT_W = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [W-1:0]     req0_x;
  logic [W-1:0]     req0_y;
  logic             req0_sel;
  logic             req1_valid;
  logic             req1_ready;
  logic [W-1:0]     req1_x;
  logic [W-1:0]     req1_y;
  logic             req1_sel;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_z;
  logic             rsp_id;
  logic [CNT_W-1:0] done0_cnt;
  logic [CNT_W-1:0] done1_cnt;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_x, req0_y, req0_sel,
    input  req1_valid, req1_x, req1_y, req1_sel,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_z, rsp_id,
    output done0_cnt, done1_cnt
  );

  // Client / consumer side
  modport master (
    output req0_valid, req0_x, req0_y, req0_sel,
    output req1_valid, req1_x, req1_y, req1_sel,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_z, rsp_id,
    input  done0_cnt, done1_cnt
  );
endinterface
`default_nettype wire

// File: rtl/calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : calc                                                      |
// | Purpose  : Combinational W-bit add/subtract, result mod 2^W          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module calc
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic         i_sel,
  output logic [W-1:0] o_z
);
  localparam logic [W-1:0] C_ONE = W'(1);

  logic [W-1:0] w_y_eff;

  // Subtract as X + two's complement of Y; carry/borrow out is discarded
  always_comb begin
    w_y_eff = i_y;
    if (i_sel == OP_SUB) begin
      w_y_eff = (~i_y) + C_ONE;
    end
    o_z = i_x + w_y_eff;
  end
endmodule
`default_nettype wire

// File: rtl/calc_arbiter_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arb2                                                   |
// | Purpose  : Two-way round-robin grant with priority pointer           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output logic       o_gnt_id
);
  logic r_ptr;

  // Pointer's requester wins if valid, otherwise the other; grant only when enabled
  always_comb begin
    o_gnt    = 2'b00;
    o_gnt_id = r_ptr;
    if (!i_req[r_ptr] && i_req[~r_ptr]) begin
      o_gnt_id = ~r_ptr;
    end
    if (i_en && (i_req != 2'b00)) begin
      o_gnt[o_gnt_id] = 1'b1;
    end
  end

  // A grant is always a handshake, so hand priority to the other side
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (o_gnt != 2'b00) begin
      r_ptr <= ~o_gnt_id;
    end
  end
endmodule
`default_nettype wire

// File: rtl/calc_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : calc_arbiter                                              |
// | Purpose  : Shares one calc datapath between two requesters           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int W     = CALC_W,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  calc_arbiter_if.slave bus
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_x;
  logic [W-1:0]     r_y;
  logic             r_sel;
  logic             r_id;
  logic [W-1:0]     r_z;
  logic [CNT_W-1:0] r_done0;
  logic [CNT_W-1:0] r_done1;
  logic [1:0]       w_gnt;
  logic             w_gnt_id;
  logic             w_acc;
  logic             w_rsp_hs;
  logic [W-1:0]     w_calc_z;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_en     (r_state == ST_IDLE),
    .i_req    ({bus.req1_valid, bus.req0_valid}),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id)
  );

  calc #(.W(W)) u_calc (
    .i_x   (r_x),
    .i_y   (r_y),
    .i_sel (r_sel),
    .o_z   (w_calc_z)
  );

  assign bus.req0_ready = w_gnt[0];
  assign bus.req1_ready = w_gnt[1];
  assign bus.rsp_z      = r_z;
  assign bus.rsp_id     = r_id;
  assign bus.done0_cnt  = r_done0;
  assign bus.done1_cnt  = r_done1;

  // Sequencing: accept in IDLE, compute for one cycle, hold result until taken
  always_comb begin
    w_state_nxt   = r_state;
    w_acc         = (w_gnt != 2'b00);
    bus.rsp_valid = (r_state == ST_RESP);
    w_rsp_hs      = bus.rsp_valid && bus.rsp_ready;
    case (r_state)
      ST_IDLE: if (w_acc)    w_state_nxt = ST_EXEC;
      ST_EXEC:               w_state_nxt = ST_RESP;
      ST_RESP: if (w_rsp_hs) w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the granted operation so the requester is free after the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_sel <= OP_ADD;
      r_id  <= 1'b0;
    end else if (w_acc) begin
      r_x   <= w_gnt_id ? bus.req1_x   : bus.req0_x;
      r_y   <= w_gnt_id ? bus.req1_y   : bus.req0_y;
      r_sel <= w_gnt_id ? bus.req1_sel : bus.req0_sel;
      r_id  <= w_gnt_id;
    end
  end

  // Result register loads only in EXEC, so it stays stable through RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_z <= '0;
    end else if (r_state == ST_EXEC) begin
      r_z <= w_calc_z;
    end
  end

  // Saturating per-requester completion counters, bumped on response handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done0 <= '0;
      r_done1 <= '0;
    end else if (w_rsp_hs) begin
      if (!r_id && (r_done0 != {CNT_W{1'b1}})) begin
        r_done0 <= r_done0 + CNT_W'(1);
      end
      if (r_id && (r_done1 != {CNT_W{1'b1}})) begin
        r_done1 <= r_done1 + CNT_W'(1);
      end
    end
  end
endmodule
`default_nettype wire
